alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue controller and register file that drives the combinational RF/ALU datapath from the operand side. It accepts one command at a time over a valid/ready handshake and reads the source registers or an immediate. It then presents operands and the 3-bit control code to the ALU, captures the ALU result and equality flag, writes the result back to the destination register, and returns a response over a second valid/ready handshake.

## Interface
- DATA_WIDTH, 32, register, operand and result width
- ADDR_WIDTH, 5, register index width; register file depth is 2**ADDR_WIDTH
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  ALU control code: 000 add, 001 sub, 010 and, 011 or, 101 eq; others undefined
- cmd_rs1, cmd_rs2, cmd_rd  in  ADDR_WIDTH  source and destination indices
- cmd_use_imm  in  1  selects cmd_imm instead of register rs2 as operand 2
- cmd_imm  in  DATA_WIDTH  immediate operand
- alu_op1, alu_op2  out  DATA_WIDTH  registered operands to the ALU
- alu_cntrl  out  3  registered control code to the ALU
- alu_out  in  DATA_WIDTH  ALU result, combinational from alu_op*/alu_cntrl
- alu_eq  in  1  ALU equality flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_result  out  DATA_WIDTH  captured alu_out
- rsp_eq  out  1  captured alu_eq
- dbg_addr  in  ADDR_WIDTH  debug read index (only with RF_DEBUG_PORT_EN)
- dbg_data  out  DATA_WIDTH  debug read data (only with RF_DEBUG_PORT_EN)

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, load alu_op1=RF[rs1] and alu_op2=(cmd_use_imm ? cmd_imm : RF[rs2]), load alu_cntrl=cmd_op, latch rd, then go to EXEC.
  - EXEC: the ALU evaluates. On the closing edge, capture alu_out into rsp_result and alu_eq into rsp_eq, perform the writeback, then go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- Register 0 reads as 0. Writes to register 0 are discarded.
- Writeback rules:
  - op 101 (eq) never writes the register file.
  - Undefined ops write alu_out (0 from the ALU) to rd.
  - All other ops write alu_out to rd.
- Arithmetic is performed in the ALU, modulo 2**DATA_WIDTH. No carry or overflow is reported.
- RF reads in IDLE see all prior writebacks, because a writeback always completes before the next accept.
- alu_op1, alu_op2, alu_cntrl, rsp_result and rsp_eq hold their values until the next accept or capture.
- Reset values:
  - state IDLE; entire register file 0.
  - alu_op1=0, alu_op2=0, alu_cntrl=000.
  - rsp_result=0, rsp_eq=0, rsp_valid=0.
  - cmd_ready=0 while rst=1, and 1 in the first cycle after rst falls.
- Reset has priority in every state. If rst is high on the EXEC closing edge, no writeback occurs and no response is produced.

## Timing
- The accept edge is the end of cycle T, where cmd_valid&&cmd_ready.
- Cycle T+1: state is EXEC and ALU inputs are valid.
- Writeback occurs on the edge ending T+1. The new register value is readable from T+2.
- Cycle T+2: rsp_valid=1 and rsp_result/rsp_eq are valid. These signals are stable while rsp_ready=0.
- If rsp_ready=1 in T+2, the next command can be accepted in T+3. Maximum throughput is one command per 3 cycles.
- cmd_ready=0 in EXEC and RESP. cmd_valid in those states is ignored and must be held by the producer.
- rsp_valid does not depend combinationally on rsp_ready. cmd_ready does not depend combinationally on cmd_valid.

## Configuration
- RF_DEBUG_PORT_EN defined:
  - adds dbg_addr/dbg_data, giving dbg_data=RF[dbg_addr] combinationally.
  - dbg_data is 0 for index 0.
  - the port is independent of the FSM and shows writes from the cycle after the writeback edge.
- RF_DEBUG_PORT_EN undefined: the ports are absent; behaviour is otherwise identical.

## Test plan
- Reset, then ADD rs1=0, imm=5, rd=1, then ADD rs1=1, imm=7, rd=2 -> responses 5 and 12, each with rsp_valid exactly 2 cycles after accept.
- SUB rs1=2, rs2=1, rd=3 -> 7. SUB rs1=0, rs2=1, rd=4 -> 0xFFFFFFFB. AND/OR of 12 and 5 -> 4 and 13.
- EQ rs1=1, rs2=1 -> rsp_eq=1, rsp_result=0. EQ rs1=1, rs2=2 -> rsp_eq=0. All registers unchanged (checked via dbg port).
- ADD rs1=0, imm=9, rd=0, then ADD rs1=0, imm=0, rd=5 -> second response is 0, confirming register 0 stays 0.
- Hold rsp_ready=0 for 3 cycles in RESP with cmd_valid=1 -> rsp_valid, rsp_result and rsp_eq stable, cmd_ready=0, no second accept until 1 cycle after rsp_ready.
- Assert rst for one cycle during EXEC of ADD imm=9, rd=6 -> register 6 stays 0, rsp_valid never asserts, and cmd_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Three-state issue controller plus register file in front of an
//            external combinational ALU. It accepts a command, presents
//            registered operands, captures the result, writes it back and
//            returns a response.
// Options  : RF_DEBUG_PORT_EN adds the dbg_addr/dbg_data register read port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef RF_DEBUG_PORT_EN
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
`endif
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_rs1,
  input  logic [ADDR_WIDTH-1:0] cmd_rs2,
  input  logic [ADDR_WIDTH-1:0] cmd_rd,
  input  logic                  cmd_use_imm,
  input  logic [DATA_WIDTH-1:0] cmd_imm,
  output logic [DATA_WIDTH-1:0] alu_op1,
  output logic [DATA_WIDTH-1:0] alu_op2,
  output logic [2:0]            alu_cntrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_eq,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_eq
);

  localparam int       DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [2:0] OP_EQ  = 3'b101;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] rf_q [DEPTH];
  logic [DATA_WIDTH-1:0] op1_q, op2_q, result_q;
  logic [2:0]            cntrl_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  eq_q;

  logic                  w_accept;
  logic                  w_wb_en;
  logic [DATA_WIDTH-1:0] w_rs1_data;
  logic [DATA_WIDTH-1:0] w_rs2_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:  cmd_ready = ~rst;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // ----------------------------------------------------------- datapath
  assign w_accept   = (state_q == S_IDLE) && cmd_valid;
  assign w_rs1_data = (cmd_rs1 == '0) ? '0 : rf_q[cmd_rs1];
  assign w_rs2_data = (cmd_rs2 == '0) ? '0 : rf_q[cmd_rs2];
  // Equality compares produce only a flag; register 0 is hard-wired to zero.
  assign w_wb_en    = (state_q == S_EXEC) && (cntrl_q != OP_EQ) && (rd_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q    <= '0;
      op2_q    <= '0;
      cntrl_q  <= 3'b000;
      rd_q     <= '0;
      result_q <= '0;
      eq_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        op1_q   <= w_rs1_data;
        op2_q   <= cmd_use_imm ? cmd_imm : w_rs2_data;
        cntrl_q <= cmd_op;
        rd_q    <= cmd_rd;
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_out;
        eq_q     <= alu_eq;
      end
      if (w_wb_en) begin
        rf_q[rd_q] <= alu_out;
      end
    end
  end

  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_cntrl  = cntrl_q;
  assign rsp_result = result_q;
  assign rsp_eq     = eq_q;

`ifdef RF_DEBUG_PORT_EN
  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// Testbench for alu_issue_ctrl: directed scenarios plus randomized commands,
// checked against an array-based register file model and an ALU stand-in.
module tb_alu_issue_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_use_imm;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic [DW-1:0] cmd_imm;
  logic [DW-1:0] alu_op1, alu_op2, alu_out;
  logic [2:0]    alu_cntrl;
  logic          alu_eq;
  logic          rsp_valid, rsp_ready, rsp_eq;
  logic [DW-1:0] rsp_result;
`ifdef RF_DEBUG_PORT_EN
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
`endif

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] m_rf [32];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef RF_DEBUG_PORT_EN
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
`endif
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_rd     (cmd_rd),
    .cmd_use_imm(cmd_use_imm),
    .cmd_imm    (cmd_imm),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_cntrl  (alu_cntrl),
    .alu_out    (alu_out),
    .alu_eq     (alu_eq),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_eq     (rsp_eq)
  );

  // Combinational ALU stand-in
  always_comb begin
    alu_out = '0;
    alu_eq  = (alu_op1 == alu_op2);
    case (alu_cntrl)
      3'b000:  alu_out = alu_op1 + alu_op2;
      3'b001:  alu_out = alu_op1 - alu_op2;
      3'b010:  alu_out = alu_op1 & alu_op2;
      3'b011:  alu_out = alu_op1 | alu_op2;
      default: alu_out = '0;
    endcase
  end

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] idx);
    return (idx == 0) ? '0 : m_rf[idx];
  endfunction

  // One full command: accept, check EXEC cycle, response and hand-back.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic [AW-1:0] rd,
                       input logic use_imm, input logic [DW-1:0] imm,
                       input int stall, input logic hold_valid,
                       output logic [DW-1:0] got, output logic goteq);
    logic [DW-1:0] a, b, exp;
    logic expeq;
    int n;
    a = rd_model(rs1);
    b = use_imm ? imm : rd_model(rs2);
    case (op)
      3'b000:  exp = a + b;
      3'b001:  exp = a - b;
      3'b010:  exp = a & b;
      3'b011:  exp = a | b;
      default: exp = 0;
    endcase
    expeq = (a == b);
    got = 'x;
    goteq = 1'bx;

    @(posedge clk); #1;
    cmd_op = op; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
    cmd_use_imm = use_imm; cmd_imm = imm; cmd_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout: cmd_ready=%b want 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = hold_valid;
    cmd_imm = ~imm;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL exec_handshake: rsp_valid=%b cmd_ready=%b want 0 0", rsp_valid, cmd_ready);
    end
    checks++;
    if (alu_op1 !== a || alu_op2 !== b || alu_cntrl !== op) begin
      errors++;
      $display("FAIL exec_operands: got %h %h %b want %h %h %b", alu_op1, alu_op2, alu_cntrl, a, b, op);
    end
    @(posedge clk); #1;
    rsp_ready = (stall == 0);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== exp || rsp_eq !== expeq || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL response: valid=%b result=%h eq=%b rdy=%b want 1 %h %b 0",
               rsp_valid, rsp_result, rsp_eq, cmd_ready, exp, expeq);
    end
    got = rsp_result;
    goteq = rsp_eq;
    for (int k = 1; k <= stall; k++) begin
      @(posedge clk); #1;
      if (k == stall) rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== exp || rsp_eq !== expeq || cmd_ready !== 1'b0
          || alu_op1 !== a || alu_op2 !== b) begin
        errors++;
        $display("FAIL stall_hold: valid=%b result=%h eq=%b rdy=%b op1=%h want 1 %h %b 0 %h",
                 rsp_valid, rsp_result, rsp_eq, cmd_ready, alu_op1, exp, expeq, a);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: cmd_ready=%b rsp_valid=%b want 1 0", cmd_ready, rsp_valid);
    end
    if (op != 3'b101 && rd != 0) m_rf[rd] = exp;
  endtask

`ifdef RF_DEBUG_PORT_EN
  task automatic check_rf_dbg(input string name);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = AW'(i);
      #1;
      checks++;
      if (dbg_data !== rd_model(AW'(i))) begin
        errors++;
        $display("FAIL %s_dbg[%0d]: got %h want %h", name, i, dbg_data, rd_model(AW'(i)));
      end
    end
  endtask
`endif

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b1; rsp_ready = 1'b0; cmd_op = 3'b000; cmd_use_imm = 1'b0;
    cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0; cmd_imm = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || alu_op1 !== 0 || alu_op2 !== 0
        || alu_cntrl !== 3'b000 || rsp_result !== 0 || rsp_eq !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b vld=%b op1=%h op2=%h c=%b res=%h eq=%b want all 0",
               cmd_ready, rsp_valid, alu_op1, alu_op2, alu_cntrl, rsp_result, rsp_eq);
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_directed();
    logic [DW-1:0] r;
    logic e;
    issue(3'b000, 5'd0, 5'd0, 5'd1, 1'b1, 32'd5, 0, 1'b0, r, e);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL add5: got %h want 5", r); end
    issue(3'b000, 5'd1, 5'd0, 5'd2, 1'b1, 32'd7, 0, 1'b0, r, e);
    checks++; if (r !== 32'd12) begin errors++; $display("FAIL add12: got %h want c", r); end
    issue(3'b001, 5'd2, 5'd1, 5'd3, 1'b0, 32'd0, 0, 1'b0, r, e);
    checks++; if (r !== 32'd7) begin errors++; $display("FAIL sub7: got %h want 7", r); end
    issue(3'b001, 5'd0, 5'd1, 5'd4, 1'b0, 32'd0, 0, 1'b0, r, e);
    checks++; if (r !== 32'hFFFF_FFFB) begin errors++; $display("FAIL sub_wrap: got %h want fffffffb", r); end
    issue(3'b010, 5'd2, 5'd1, 5'd7, 1'b0, 32'd0, 0, 1'b0, r, e);
    checks++; if (r !== 32'd4) begin errors++; $display("FAIL and: got %h want 4", r); end
    issue(3'b011, 5'd2, 5'd1, 5'd8, 1'b0, 32'd0, 0, 1'b0, r, e);
    checks++; if (r !== 32'd13) begin errors++; $display("FAIL or: got %h want d", r); end
  endtask

  task automatic test_eq();
    logic [DW-1:0] r;
    logic e;
    issue(3'b101, 5'd1, 5'd1, 5'd3, 1'b0, 32'd0, 0, 1'b0, r, e);
    checks++;
    if (r !== 0 || e !== 1'b1) begin errors++; $display("FAIL eq_same: got %h %b want 0 1", r, e); end
    issue(3'b101, 5'd1, 5'd2, 5'd4, 1'b0, 32'd0, 0, 1'b0, r, e);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL eq_diff: got %b want 0", e); end
    // r3 and r4 must still hold 7 and -5
    issue(3'b000, 5'd3, 5'd4, 5'd0, 1'b0, 32'd0, 0, 1'b0, r, e);
    checks++;
    if (r !== 32'd2) begin errors++; $display("FAIL eq_nowrite: got %h want 2", r); end
`ifdef RF_DEBUG_PORT_EN
    check_rf_dbg("eq");
`endif
  endtask

  task automatic test_reg0();
    logic [DW-1:0] r;
    logic e;
    issue(3'b000, 5'd0, 5'd0, 5'd0, 1'b1, 32'd9, 0, 1'b0, r, e);
    issue(3'b000, 5'd0, 5'd0, 5'd5, 1'b1, 32'd0, 0, 1'b0, r, e);
    checks++;
    if (r !== 0) begin errors++; $display("FAIL reg0: got %h want 0", r); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] r;
    logic e;
    issue(3'b000, 5'd1, 5'd2, 5'd9, 1'b0, 32'd0, 3, 1'b1, r, e);
    checks++;
    if (r !== 32'd17) begin errors++; $display("FAIL stall_add: got %h want 11", r); end
  endtask

  task automatic test_reset_in_exec();
    int seen;
    @(posedge clk); #1;
    cmd_op = 3'b000; cmd_rs1 = '0; cmd_rd = 5'd6; cmd_use_imm = 1'b1; cmd_imm = 32'd9;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_exec_ready: got %b want 0", cmd_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_release: got %b want 1", cmd_ready); end
    seen = 0;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    rsp_ready = 1'b0;
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_exec_rsp: rsp_valid high %0d cycles want 0", seen); end
`ifdef RF_DEBUG_PORT_EN
    check_rf_dbg("rst_exec");
`endif
    begin
      logic [DW-1:0] r;
      logic e;
      issue(3'b011, 5'd6, 5'd1, 5'd0, 1'b0, 32'd0, 0, 1'b0, r, e);
      checks++;
      if (r !== 0) begin errors++; $display("FAIL rst_exec_r6: got %h want 0", r); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] r;
    logic e;
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      issue(op, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)), r, e);
    end
`ifdef RF_DEBUG_PORT_EN
    check_rf_dbg("random");
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_eq();
    test_reg0();
    test_back_to_back();
    test_reset_in_exec();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
